// File: rtl/sap1_controller_sequencer.sv
// sap1_controller_sequencer
// Six-state T-cycle ring with opcode decode for the SAP-1 datapath.
// Each control output drives one datapath resource. The control word is
// combinational from the registered T-state and the live opcode.
// Optional macro SAP1_JMP_EN: when defined, opcode 4'b0011 decodes as JMP
// (T4 drives EI,LP). When undefined, that opcode is a NOP and LP is tied 0.
module sap1_controller_sequencer (
   input  logic       CLK,
   input  logic       RST,
   input  logic [3:0] opcode,
   output logic [5:0] tstate,
   output logic       CP,
   output logic       EP,
   output logic       LM,
   output logic       CE,
   output logic       LI,
   output logic       EI,
   output logic       LA,
   output logic       EA,
   output logic       SU,
   output logic       EU,
   output logic       LB,
   output logic       LO,
   output logic       LP,
   output logic       HALTED
);

   localparam logic [3:0] OP_LDA = 4'b0000;
   localparam logic [3:0] OP_ADD = 4'b0001;
   localparam logic [3:0] OP_SUB = 4'b0010;
   localparam logic [3:0] OP_JMP = 4'b0011;
   localparam logic [3:0] OP_OUT = 4'b1110;
   localparam logic [3:0] OP_HLT = 4'b1111;

   typedef enum logic [2:0] {
      S_T1   = 3'd0,
      S_T2   = 3'd1,
      S_T3   = 3'd2,
      S_T4   = 3'd3,
      S_T5   = 3'd4,
      S_T6   = 3'd5,
      S_HALT = 3'd6
   } state_t;

   state_t state, state_nxt;

   // State register: reset always restarts the ring at T1, even from HALT
   always_ff @(posedge CLK) begin
      if (RST) state <= S_T1;
      else     state <= state_nxt;
   end

   // Next-state: fixed six-cycle ring; HLT diverts to HALT after T4
   always_comb begin
      state_nxt = S_T1;
      case (state)
         S_T1:    state_nxt = S_T2;
         S_T2:    state_nxt = S_T3;
         S_T3:    state_nxt = S_T4;
         S_T4:    state_nxt = (opcode == OP_HLT) ? S_HALT : S_T5;
         S_T5:    state_nxt = S_T6;
         S_T6:    state_nxt = S_T1;
         S_HALT:  state_nxt = S_HALT;
         default: state_nxt = S_T1;
      endcase
   end

   // Outputs: T-state decode plus the per-state control word, forced off in reset
   always_comb begin
      tstate = 6'b000000;
      HALTED = 1'b0;
      CP = 1'b0; EP = 1'b0; LM = 1'b0; CE = 1'b0; LI = 1'b0; EI = 1'b0;
      LA = 1'b0; EA = 1'b0; SU = 1'b0; EU = 1'b0; LB = 1'b0; LO = 1'b0;
      LP = 1'b0;

      case (state)
         S_T1:    tstate = 6'b000001;
         S_T2:    tstate = 6'b000010;
         S_T3:    tstate = 6'b000100;
         S_T4:    tstate = 6'b001000;
         S_T5:    tstate = 6'b010000;
         S_T6:    tstate = 6'b100000;
         S_HALT:  HALTED = 1'b1;
         default: tstate = 6'b000000;
      endcase

      if (!RST) begin
         case (state)
            S_T1: begin
               EP = 1'b1;
               LM = 1'b1;
            end
            S_T2: CP = 1'b1;
            S_T3: begin
               CE = 1'b1;
               LI = 1'b1;
            end
            S_T4: begin
               case (opcode)
                  OP_LDA, OP_ADD, OP_SUB: begin
                     EI = 1'b1;
                     LM = 1'b1;
                  end
                  OP_OUT: begin
                     EA = 1'b1;
                     LO = 1'b1;
                  end
`ifdef SAP1_JMP_EN
                  OP_JMP: begin
                     EI = 1'b1;
                     LP = 1'b1;
                  end
`endif
                  default: ;
               endcase
            end
            S_T5: begin
               case (opcode)
                  OP_LDA: begin
                     CE = 1'b1;
                     LA = 1'b1;
                  end
                  OP_ADD, OP_SUB: begin
                     CE = 1'b1;
                     LB = 1'b1;
                  end
                  default: ;
               endcase
            end
            S_T6: begin
               case (opcode)
                  OP_ADD: begin
                     EU = 1'b1;
                     LA = 1'b1;
                  end
                  OP_SUB: begin
                     EU = 1'b1;
                     SU = 1'b1;
                     LA = 1'b1;
                  end
                  default: ;
               endcase
            end
            default: ;
         endcase
      end
   end

endmodule
